// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table scanner: steps a combinational function under test through every
// input vector, captures its output and scores the captured table against an expected mask.
module truth_table_scanner #(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vars,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch,
  output logic [N_IN-1:0]      first_err,
  output logic                 err_valid,
  output logic                 pass
);

  localparam int W  = 2**N_IN;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [N_IN-1:0] LAST_IDX    = '1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYC - 1);

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    exp_q;

  logic            miss;
  logic [N_IN:0]   mismatch_nxt;

  assign miss         = (f_in != exp_q[idx]);
  assign mismatch_nxt = mismatch + {{N_IN{1'b0}}, miss};

  // vars is parked at 0 outside the active vectors so the FUT sees a stable input.
  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign vars = busy ? idx : '0;
  assign done = (state == DONE);

  // NOTE: every register here is updated with <= so all reads in this block see the
  // pre-edge values; mixing in blocking writes would make the update order matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      table_out <= '0;
      mismatch  <= '0;
      first_err <= '0;
      err_valid <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q     <= expected;
            idx       <= '0;
            cnt       <= '0;
            table_out <= '0;
            mismatch  <= '0;
            first_err <= '0;
            err_valid <= 1'b0;
            pass      <= 1'b0;
            state     <= SETTLE;
          end
        end

        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SAMPLE: begin
          table_out[idx] <= f_in;
          mismatch       <= mismatch_nxt;
          if (miss && !err_valid) begin
            first_err <= idx;
            err_valid <= 1'b1;
          end
          // pass is resolved on the final sample so it is already valid during the done pulse.
          if (idx == LAST_IDX) begin
            pass  <= (mismatch_nxt == '0);
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= SETTLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: a behavioural FUT lookup table is looped back to f_in
// and each scenario checks the captured table, statistics, timing and vector sequencing.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] expected;
  logic        f_in;
  logic [3:0]  vars;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  mismatch;
  logic [3:0]  first_err;
  logic        err_valid;
  logic        pass;

  logic        start3;
  logic [15:0] expected3;
  logic        f_in3;
  logic [3:0]  vars3;
  logic        busy3;
  logic        done3;
  logic [15:0] table3;
  logic [4:0]  mismatch3;
  logic [3:0]  first_err3;
  logic        err_valid3;
  logic        pass3;

  logic [15:0] fut_tab;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  assign f_in  = fut_tab[vars];
  assign f_in3 = fut_tab[vars3];

  truth_table_scanner #(.N_IN(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .f_in(f_in),
    .vars(vars), .busy(busy), .done(done), .table_out(table_out), .mismatch(mismatch),
    .first_err(first_err), .err_valid(err_valid), .pass(pass)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(expected3), .f_in(f_in3),
    .vars(vars3), .busy(busy3), .done(done3), .table_out(table3), .mismatch(mismatch3),
    .first_err(first_err3), .err_valid(err_valid3), .pass(pass3)
  );

  // Start accepted at edge 0; cycle c is the interval after edge c-1. Observation is #1 after the edge.
  task automatic run_scan(input logic [15:0] exp_v, input int n_cyc, input int pulse_a,
                          input int pulse_b, input int chg_cyc, input logic [15:0] chg_exp,
                          input bit hold_start, output int first_done, output int last_done,
                          output int n_done, output logic pass_at_done);
    expected = exp_v;
    start    = 1'b1;
    @(posedge clk); #1;
    first_done   = 0;
    last_done    = 0;
    n_done       = 0;
    pass_at_done = 1'b0;
    for (int c = 1; c <= n_cyc; c++) begin
      start = hold_start || (c == pulse_a) || (c == pulse_b);
      if (c == chg_cyc) expected = chg_exp;
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) begin
          first_done   = c;
          pass_at_done = pass;
        end
        last_done = c;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
    expected = 16'h0; expected3 = 16'hB6A8; fut_tab = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({vars, busy, done, err_valid, pass} !== 8'h00)
      $display("FAIL reset_ctrl: got %h required 00", {vars, busy, done, err_valid, pass});
    else passes++;
    checks++;
    if ({table_out, mismatch, first_err} !== 25'h0)
      $display("FAIL reset_results: got %h required 0", {table_out, mismatch, first_err});
    else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback(input string tag);
    int fd, ld, nd;
    logic pd;
    fut_tab = 16'hB6A8;
    run_scan(16'hB6A8, 40, -1, -1, -1, 16'h0, 1'b0, fd, ld, nd, pd);
    checks++;
    if (fd !== 33) $display("FAIL %s_done_cycle: got %0d required 33", tag, fd); else passes++;
    checks++;
    if (nd !== 1) $display("FAIL %s_done_count: got %0d required 1", tag, nd); else passes++;
    checks++;
    if (pd !== 1'b1) $display("FAIL %s_pass_at_done: got %b required 1", tag, pd); else passes++;
    checks++;
    if (table_out !== 16'hB6A8) $display("FAIL %s_table: got %h required b6a8", tag, table_out); else passes++;
    checks++;
    if (mismatch !== 5'd0) $display("FAIL %s_mismatch: got %0d required 0", tag, mismatch); else passes++;
    checks++;
    if (err_valid !== 1'b0) $display("FAIL %s_err_valid: got %b required 0", tag, err_valid); else passes++;
    checks++;
    if (pass !== 1'b1) $display("FAIL %s_pass_idle: got %b required 1", tag, pass); else passes++;
  endtask

  task automatic test_stuck_at_0;
    int fd, ld, nd;
    logic pd;
    fut_tab = 16'h0000;
    run_scan(16'hB6A8, 40, -1, -1, -1, 16'h0, 1'b0, fd, ld, nd, pd);
    checks++;
    if (table_out !== 16'h0000) $display("FAIL stuck_table: got %h required 0000", table_out); else passes++;
    checks++;
    if (mismatch !== 5'd8) $display("FAIL stuck_mismatch: got %0d required 8", mismatch); else passes++;
    checks++;
    if (first_err !== 4'd3) $display("FAIL stuck_first_err: got %0d required 3", first_err); else passes++;
    checks++;
    if (err_valid !== 1'b1) $display("FAIL stuck_err_valid: got %b required 1", err_valid); else passes++;
    checks++;
    if ({pd, pass} !== 2'b00) $display("FAIL stuck_pass: got %b required 00", {pd, pass}); else passes++;
  endtask

  task automatic test_inverted;
    int fd, ld, nd;
    logic pd;
    fut_tab = 16'h4957;
    run_scan(16'hB6A8, 40, -1, -1, -1, 16'h0, 1'b0, fd, ld, nd, pd);
    checks++;
    if (table_out !== 16'h4957) $display("FAIL inv_table: got %h required 4957", table_out); else passes++;
    checks++;
    if (mismatch !== 5'd16) $display("FAIL inv_mismatch: got %0d required 16", mismatch); else passes++;
    checks++;
    if (first_err !== 4'd0) $display("FAIL inv_first_err: got %0d required 0", first_err); else passes++;
    checks++;
    if ({err_valid, pass} !== 2'b10) $display("FAIL inv_flags: got %b required 10", {err_valid, pass}); else passes++;
  endtask

  task automatic test_reset_mid_scan;
    int nd;
    fut_tab  = 16'h4957;
    expected = 16'hB6A8;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", busy); else passes++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({vars, busy, done, err_valid, pass} !== 8'h00)
      $display("FAIL midrst_ctrl: got %h required 00", {vars, busy, done, err_valid, pass});
    else passes++;
    checks++;
    if ({table_out, mismatch, first_err} !== 25'h0)
      $display("FAIL midrst_results: got %h required 0", {table_out, mismatch, first_err});
    else passes++;
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) nd++;
      @(posedge clk); #1;
    end
    checks++;
    if (nd !== 0) $display("FAIL midrst_no_done: got %0d pulses required 0", nd); else passes++;
    test_loopback("midrst_rerun");
  endtask

  task automatic test_ignored_stimuli;
    int fd, ld, nd;
    logic pd;
    fut_tab = 16'hB6A8;
    run_scan(16'hB6A8, 70, 5, 33, 8, 16'h0000, 1'b0, fd, ld, nd, pd);
    checks++;
    if (nd !== 1 || fd !== 33) $display("FAIL ign_single_scan: got %0d pulses first %0d required 1 at 33", nd, fd); else passes++;
    checks++;
    if ({mismatch, err_valid, pass} !== 7'b0000001)
      $display("FAIL ign_results: got mismatch %0d err_valid %b pass %b required 0 0 1", mismatch, err_valid, pass);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL ign_idle_after: got busy %b required 0", busy); else passes++;
  endtask

  task automatic test_back_to_back;
    int fd, ld, nd;
    logic pd;
    fut_tab = 16'hB6A8;
    run_scan(16'hB6A8, 68, -1, -1, -1, 16'h0, 1'b1, fd, ld, nd, pd);
    checks++;
    if (nd !== 2) $display("FAIL b2b_done_count: got %0d required 2", nd); else passes++;
    checks++;
    if (fd !== 33 || ld !== 67) $display("FAIL b2b_done_cycles: got %0d,%0d required 33,67", fd, ld); else passes++;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_sequencing;
    logic [3:0] want;
    fut_tab  = 16'hB6A8;
    expected = 16'hB6A8;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      want = (c <= 32) ? 4'((c - 1) / 2) : 4'd0;
      checks++;
      if (vars !== want) $display("FAIL seq1_vars_c%0d: got %0d required %0d", c, vars, want); else passes++;
      @(posedge clk); #1;
    end
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int c = 1; c <= 65; c++) begin
      want = (c <= 64) ? 4'((c - 1) / 4) : 4'd0;
      checks++;
      if (vars3 !== want) $display("FAIL seq3_vars_c%0d: got %0d required %0d", c, vars3, want); else passes++;
      if (c == 65) begin
        checks++;
        if ({done3, pass3, table3} !== {2'b11, 16'hB6A8})
          $display("FAIL seq3_done: got done %b pass %b table %h required 1 1 b6a8", done3, pass3, table3);
        else passes++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_loopback("loopback");
    test_stuck_at_0();
    test_inverted();
    test_reset_mid_scan();
    test_ignored_stimuli();
    test_back_to_back();
    test_sequencing();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
